peak_dpu_ls_ctrl: RTL and testbench
===================================

Name: peak_dpu_ls_ctrl

Overview:
Load/store sequencer between the decode/issue stage and the single-port data bus of the MCU.
- Accepts one decoded ld/st operation at a time: 3-bit ls op, effective address, store data, destination register.
- Checks alignment, generates byte enables and store lane replication, and runs the bus request/grant/response handshake.
- Sign/zero-extends load data and returns a registered writeback or an exception to the pipeline.

Parameters:
TIMEOUT_CYC, 255, cycles allowed from request launch to response before abort (1..255, counter 8 bits)
RESET_PC_ALIGN, 2, number of address LSBs cleared to form word address dbus_addr (fixed 32-bit bus)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ls_req_vld  in  1  issue presents an ld/st op
ls_req_rdy  out  1  controller can accept (IDLE only)
ls_op  in  3  LB=0 LH=1 LW=2 LBU=3 LHU=4 SB=5 SH=6 SW=7
ls_addr  in  32  effective byte address
ls_wdata  in  32  store data (rs2)
ls_rd_addr  in  5  load destination register
dbus_req  out  1  bus request, held until dbus_gnt
dbus_addr  out  32  word-aligned address
dbus_we  out  1  1=store
dbus_be  out  4  byte enables
dbus_wdata  out  32  lane-replicated store data
dbus_gnt  in  1  request accepted this cycle
dbus_rvld  in  1  response (load data or store ack)
dbus_rdata  in  32  load data
dbus_err  in  1  bus error, qualified by dbus_rvld
wb_vld  out  1  load writeback pulse
wb_addr  out  5  writeback register
wb_data  out  32  extended load data
ls_done  out  1  pulse: op retired (success or exception)
ls_exc_vld  out  1  pulse: exception
ls_exc_cause  out  2  1=misaligned, 2=bus error, 3=timeout

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0 except ls_req_rdy=1. dbus_req drops immediately. Timeout counter = 0. Reset mid-transaction abandons the op with no writeback.
- Handshake: an op is accepted on ls_req_vld & ls_req_rdy. Op, addr, wdata and rd are captured into registers. ls_req_rdy=1 only in IDLE.
- Misalignment:
  - LH/LHU/SH with addr[0]=1 is misaligned.
  - LW/SW with addr[1:0]!=0 is misaligned.
- States: IDLE -> REQ -> WAIT -> RESP -> IDLE. The path IDLE -> EXC -> IDLE handles the misaligned case without the optional feature.
- REQ:
  - dbus_req=1; addr/we/be/wdata stable until dbus_gnt.
  - On gnt -> WAIT. dbus_rvld in REQ is ignored.
- WAIT:
  - dbus_rvld with dbus_err=0 -> RESP.
  - dbus_rvld with dbus_err=1 -> EXC, cause 2.
- Timeout: the counter runs in REQ+WAIT. When it reaches TIMEOUT_CYC -> EXC, cause 3, and dbus_req is deasserted. A dbus_rvld arriving later in IDLE is dropped.
- RESP (one cycle): ls_done=1; for loads, wb_vld=1 with wb_data/wb_addr. Load latency is gnt-to-rvld + 1 cycle.
- Loads to rd=0: wb_vld=0, ls_done still 1.
- EXC (one cycle): ls_exc_vld=1, ls_done=1, wb_vld=0.
- Byte enables:
  - SB/LB/LBU: 4'b0001<<addr[1:0]
  - SH/LH/LHU: 4'b0011<<addr[1:0]
  - SW/LW: 4'hF
- Store data: SB -> {4{wdata[7:0]}}; SH -> {2{wdata[15:0]}}; SW -> wdata.
- Load extract: byte/half lane is selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- dbus_addr = {addr[31:2],2'b00}, flopped.

Optional Feature:
PEAK_DPU_LS_MISALIGN_SPLIT_EN
- Defined: misaligned ops are split into two word accesses (states REQ2/WAIT2).
  - First access: word at addr, with lanes addr[1:0]..3.
  - Second access: word at addr+4 (32-bit wrap), with the remaining low lanes.
  - Loads merge both responses before extension; no exception.
  - Error/timeout on either access -> cause 2/3, no writeback. A store's first half stays written; there is no rollback.
- Undefined: misaligned -> EXC cause 1, zero bus activity.

Decomposition:
- Package peak_dpu_ls_pkg holds:
  - ls op encodings LB..SW
  - exception cause codes
  - FSM state encoding
  - TIMEOUT counter width
- One combinational sub-module, peak_dpu_ls_align, maps op/addr[1:0]/wdata to be/wdata, rdata to extended load data, and flags misaligned.
- The FSM, counter and registers stay in peak_dpu_ls_ctrl.

Test Plan:
- LB addr 0x1003, rdata 0x80XXXXXX, gnt after 2 cycles -> be=4'b1000, wb_data=0xFFFFFF80, wb_addr=rd, one wb_vld pulse.
- SH addr 0x2002, wdata 0x0000BEEF -> dbus_we=1, be=4'b1100, dbus_wdata=0xBEEFBEEF, ls_done after rvld, wb_vld=0.
- LW addr 0x1001, feature off -> no dbus_req, ls_exc_vld cause 1 next cycle. Feature on: two reads 0x1000/0x1004 with rdata 0x44332211/0x88776655 -> wb_data=0x55443322.
- dbus_gnt never asserted, TIMEOUT_CYC=4 -> dbus_req drops, exc cause 3 four cycles after launch; a later rvld is ignored, ls_req_rdy=1.
- LHU addr 0x10, rvld with dbus_err=1 -> exc cause 2, no wb. Load to rd=0 -> ls_done=1, wb_vld=0.
- rst_n low while in WAIT -> dbus_req=0 and ls_req_rdy=1 immediately; no wb/exc pulse after release.

Source files
------------

// File: rtl/peak_dpu_ls_pkg.sv
// Shared definitions for the peak_dpu load/store sequencer: op encodings,
// exception causes, FSM state encoding and timeout counter width.
package peak_dpu_ls_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } ls_op_e;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_BUS_ERR  = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_EXC   = 3'd4,
        ST_REQ2  = 3'd5,
        ST_WAIT2 = 3'd6
    } ls_state_e;

    localparam int TMO_W = 8;

    // Half accesses need an even address, word accesses a word-aligned one.
    function automatic logic ls_misaligned(input ls_op_e op, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: mis = lo[0];
            OP_LW, OP_SW:         mis = (lo != 2'b00);
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/peak_dpu_ls_align.sv
// Lane logic for the load/store sequencer: byte enables, store lane
// replication, load extraction/extension and misalignment flag.
// PEAK_DPU_LS_MISALIGN_SPLIT_EN adds the second-word lanes for split accesses.
module peak_dpu_ls_align
    import peak_dpu_ls_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
`ifdef PEAK_DPU_LS_MISALIGN_SPLIT_EN
    input  logic [31:0] rdata_hi,
    output logic [3:0]  be_hi,
    output logic [31:0] wdata_hi,
`endif
    output logic [3:0]  be,
    output logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic        misaligned
);

    ls_op_e      op_e;
    logic [3:0]  base;
    logic [31:0] rep;
    logic [31:0] rsh;

    assign op_e       = ls_op_e'(op);
    assign misaligned = ls_misaligned(op_e, addr_lo);

    // Access size mask and replicated store data.
    always_comb begin
        base = 4'hF;
        rep  = wdata;
        case (op_e)
            OP_LB, OP_LBU, OP_SB: begin
                base = 4'b0001;
                rep  = {4{wdata[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                base = 4'b0011;
                rep  = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef PEAK_DPU_LS_MISALIGN_SPLIT_EN
    logic [7:0]  be8;
    logic [63:0] wd64;
    logic [63:0] rd64;

    // Lanes past byte 3 spill into the next word.
    assign be8      = {4'b0000, base} << addr_lo;
    assign be       = be8[3:0];
    assign be_hi    = be8[7:4];
    assign wd64     = {32'b0, wdata} << {addr_lo, 3'b000};
    assign st_data  = misaligned ? wd64[31:0] : rep;
    assign wdata_hi = wd64[63:32];
    assign rd64     = {rdata_hi, rdata};
    assign rsh      = 32'(rd64 >> {addr_lo, 3'b000});
`else
    assign be      = base << addr_lo;
    assign st_data = rep;
    assign rsh     = rdata >> {addr_lo, 3'b000};
`endif

    // Extract the addressed lane and extend it.
    always_comb begin
        ld_data = rsh;
        case (op_e)
            OP_LB:   ld_data = {{24{rsh[7]}}, rsh[7:0]};
            OP_LBU:  ld_data = {24'b0, rsh[7:0]};
            OP_LH:   ld_data = {{16{rsh[15]}}, rsh[15:0]};
            OP_LHU:  ld_data = {16'b0, rsh[15:0]};
            default: ld_data = rsh;
        endcase
    end

endmodule

// File: rtl/peak_dpu_ls_ctrl.sv
// Load/store sequencer between issue and the single-port data bus.
// Optional: PEAK_DPU_LS_MISALIGN_SPLIT_EN splits misaligned ops into two
// word accesses instead of raising a misaligned exception.
//
// state | meaning
// IDLE  | ready for a new op
// REQ   | bus request held until grant
// WAIT  | granted, waiting for response
// RESP  | one-cycle retire, load writeback
// EXC   | one-cycle exception retire
// REQ2  | second-word request (split build only)
// WAIT2 | second-word response (split build only)
module peak_dpu_ls_ctrl
    import peak_dpu_ls_pkg::*;
#(
    parameter int TIMEOUT_CYC    = 255,
    parameter int RESET_PC_ALIGN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ls_req_vld,
    output logic        ls_req_rdy,
    input  logic [2:0]  ls_op,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [4:0]  ls_rd_addr,
    output logic        dbus_req,
    output logic [31:0] dbus_addr,
    output logic        dbus_we,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_gnt,
    input  logic        dbus_rvld,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_err,
    output logic        wb_vld,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        ls_done,
    output logic        ls_exc_vld,
    output logic [1:0]  ls_exc_cause
);

    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [31:0]      ADDR_MASK = ~((32'd1 << RESET_PC_ALIGN) - 32'd1);

    ls_state_e         state_q, state_d;
    logic [2:0]        op_q;
    logic [1:0]        addr_lo_q;
    logic [31:0]       wdata_q;
    logic [4:0]        rd_q;
    logic [31:0]       dbus_addr_q;
    logic [31:0]       rdata_q;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        cause_q, cause_d;
    logic              tmo_hit, is_load, is_store, accept;
    logic [2:0]        op_sel;
    logic [1:0]        lo_sel;
    logic [3:0]        al_be, bus_be;
    logic [31:0]       al_st_data, al_ld_data, bus_wd;
    logic              al_mis;

    assign accept   = ls_req_vld & ls_req_rdy;
    assign is_load  = (op_q <= 3'd4);
    assign is_store = (op_q >= 3'd5);
    assign tmo_hit  = (cnt_q >= TMO_LAST);
    // In IDLE the lane logic looks at the incoming op to decide misalignment.
    assign op_sel   = (state_q == ST_IDLE) ? ls_op : op_q;
    assign lo_sel   = (state_q == ST_IDLE) ? ls_addr[1:0] : addr_lo_q;

`ifdef PEAK_DPU_LS_MISALIGN_SPLIT_EN
    logic [31:0] rdata_hi_q;
    logic [3:0]  al_be_hi;
    logic [31:0] al_wdata_hi;
    logic        need_second;

    assign need_second = al_mis & (al_be_hi != 4'b0000);
    assign bus_be      = (state_q == ST_REQ2) ? al_be_hi : al_be;
    assign bus_wd      = (state_q == ST_REQ2) ? al_wdata_hi : al_st_data;
`else
    assign bus_be      = al_be;
    assign bus_wd      = al_st_data;
`endif

    peak_dpu_ls_align u_align (
        .op         (op_sel),
        .addr_lo    (lo_sel),
        .wdata      (wdata_q),
        .rdata      (rdata_q),
`ifdef PEAK_DPU_LS_MISALIGN_SPLIT_EN
        .rdata_hi   (rdata_hi_q),
        .be_hi      (al_be_hi),
        .wdata_hi   (al_wdata_hi),
`endif
        .be         (al_be),
        .st_data    (al_st_data),
        .ld_data    (al_ld_data),
        .misaligned (al_mis)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state, timeout counter and control outputs.
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        cnt_d      = '0;
        ls_req_rdy = 1'b0;
        dbus_req   = 1'b0;
        ls_done    = 1'b0;
        ls_exc_vld = 1'b0;
        wb_vld     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ls_req_rdy = 1'b1;
                cause_d    = CAUSE_NONE;
                if (ls_req_vld) begin
`ifdef PEAK_DPU_LS_MISALIGN_SPLIT_EN
                    state_d = ST_REQ;
`else
                    if (al_mis) begin
                        state_d = ST_EXC;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d = ST_REQ;
                    end
`endif
                end
            end
            ST_REQ: begin
                dbus_req = 1'b1;
                cnt_d    = cnt_q + TMO_W'(1);
                if (dbus_gnt) state_d = ST_WAIT;
                else if (tmo_hit) begin
                    state_d = ST_EXC;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + TMO_W'(1);
                if (dbus_rvld && dbus_err) begin
                    state_d = ST_EXC;
                    cause_d = CAUSE_BUS_ERR;
                end else if (dbus_rvld) begin
`ifdef PEAK_DPU_LS_MISALIGN_SPLIT_EN
                    if (need_second) begin
                        state_d = ST_REQ2;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_RESP;
                    end
`else
                    state_d = ST_RESP;
`endif
                end else if (tmo_hit) begin
                    state_d = ST_EXC;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
`ifdef PEAK_DPU_LS_MISALIGN_SPLIT_EN
            ST_REQ2: begin
                dbus_req = 1'b1;
                cnt_d    = cnt_q + TMO_W'(1);
                if (dbus_gnt) state_d = ST_WAIT2;
                else if (tmo_hit) begin
                    state_d = ST_EXC;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_WAIT2: begin
                cnt_d = cnt_q + TMO_W'(1);
                if (dbus_rvld && dbus_err) begin
                    state_d = ST_EXC;
                    cause_d = CAUSE_BUS_ERR;
                end else if (dbus_rvld) begin
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    state_d = ST_EXC;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
`endif
            ST_RESP: begin
                ls_done = 1'b1;
                wb_vld  = is_load & (rd_q != 5'd0);
                state_d = ST_IDLE;
            end
            ST_EXC: begin
                ls_done    = 1'b1;
                ls_exc_vld = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Op capture, response data, cause and timeout counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            addr_lo_q   <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            dbus_addr_q <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            cause_q     <= CAUSE_NONE;
`ifdef PEAK_DPU_LS_MISALIGN_SPLIT_EN
            rdata_hi_q  <= '0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            if (accept) begin
                op_q        <= ls_op;
                addr_lo_q   <= ls_addr[1:0];
                wdata_q     <= ls_wdata;
                rd_q        <= ls_rd_addr;
                dbus_addr_q <= ls_addr & ADDR_MASK;
            end
            if (state_q == ST_WAIT && dbus_rvld && !dbus_err) rdata_q <= dbus_rdata;
`ifdef PEAK_DPU_LS_MISALIGN_SPLIT_EN
            if (state_q == ST_WAIT2 && dbus_rvld && !dbus_err) rdata_hi_q <= dbus_rdata;
            if (state_q == ST_WAIT && state_d == ST_REQ2) dbus_addr_q <= dbus_addr_q + 32'd4;
`endif
        end
    end

    assign dbus_addr    = dbus_addr_q;
    assign dbus_we      = dbus_req & is_store;
    assign dbus_be      = dbus_req ? bus_be : 4'b0000;
    assign dbus_wdata   = dbus_req ? bus_wd : 32'd0;
    assign wb_addr      = wb_vld ? rd_q : 5'd0;
    assign wb_data      = wb_vld ? al_ld_data : 32'd0;
    assign ls_exc_cause = ls_exc_vld ? cause_q : CAUSE_NONE;

endmodule

// File: tb/tb_peak_dpu_ls_ctrl.sv
// Directed table-driven bench for peak_dpu_ls_ctrl (TIMEOUT_CYC=4).
module tb_peak_dpu_ls_ctrl;
    import peak_dpu_ls_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ls_req_vld = 1'b0;
    logic        ls_req_rdy;
    logic [2:0]  ls_op = 3'd0;
    logic [31:0] ls_addr = 32'd0;
    logic [31:0] ls_wdata = 32'd0;
    logic [4:0]  ls_rd_addr = 5'd0;
    logic        dbus_req;
    logic [31:0] dbus_addr;
    logic        dbus_we;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt = 1'b0;
    logic        dbus_rvld = 1'b0;
    logic [31:0] dbus_rdata = 32'd0;
    logic        dbus_err = 1'b0;
    logic        wb_vld;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ls_done;
    logic        ls_exc_vld;
    logic [1:0]  ls_exc_cause;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    peak_dpu_ls_ctrl #(.TIMEOUT_CYC(4), .RESET_PC_ALIGN(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .ls_req_vld(ls_req_vld), .ls_req_rdy(ls_req_rdy),
        .ls_op(ls_op), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rd_addr(ls_rd_addr),
        .dbus_req(dbus_req), .dbus_addr(dbus_addr), .dbus_we(dbus_we), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvld(dbus_rvld),
        .dbus_rdata(dbus_rdata), .dbus_err(dbus_err),
        .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_data(wb_data),
        .ls_done(ls_done), .ls_exc_vld(ls_exc_vld), .ls_exc_cause(ls_exc_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          gd;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  be;
        logic        we;
        logic [31:0] bus_wdata;
        logic        wbv;
        logic [31:0] wbd;
        logic [1:0]  cause;
    } vec_t;

    vec_t vecs[$];
    vec_t v;

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [4:0] rd, input int gd,
                                input logic [31:0] rdata, input logic err, input logic [3:0] be,
                                input logic we, input logic [31:0] bus_wdata, input logic wbv,
                                input logic [31:0] wbd, input logic [1:0] cause);
        vec_t r;
        r.op = op; r.addr = addr; r.wdata = wdata; r.rd = rd; r.gd = gd;
        r.rdata = rdata; r.err = err; r.be = be; r.we = we; r.bus_wdata = bus_wdata;
        r.wbv = wbv; r.wbd = wbd; r.cause = cause;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        @(negedge clk);
        chk("rdy_before_issue", ls_req_rdy, 1);
        ls_req_vld = 1'b1; ls_op = op; ls_addr = addr; ls_wdata = wdata; ls_rd_addr = rd;
        @(negedge clk);
        ls_req_vld = 1'b0;
    endtask

    task automatic run_vec(input vec_t t);
        issue(t.op, t.addr, t.wdata, t.rd);
        if (t.cause == CAUSE_MISALIGN) begin
            chk("mis_no_req", dbus_req, 0);
            chk("mis_exc_vld", ls_exc_vld, 1);
            chk("mis_cause", ls_exc_cause, CAUSE_MISALIGN);
            chk("mis_done", ls_done, 1);
            chk("mis_no_wb", wb_vld, 0);
        end else begin
            chk("req", dbus_req, 1);
            chk("addr", dbus_addr, t.addr & 32'hFFFF_FFFC);
            chk("we", dbus_we, t.we);
            chk("be", dbus_be, t.be);
            chk("bus_wdata", dbus_wdata, t.bus_wdata);
            repeat (t.gd) begin
                @(negedge clk);
                chk("req_held", dbus_req, 1);
                chk("be_held", dbus_be, t.be);
            end
            dbus_gnt = 1'b1;
            @(negedge clk);
            dbus_gnt = 1'b0;
            chk("req_after_gnt", dbus_req, 0);
            chk("no_done_in_wait", ls_done, 0);
            dbus_rvld = 1'b1; dbus_rdata = t.rdata; dbus_err = t.err;
            @(negedge clk);
            dbus_rvld = 1'b0; dbus_err = 1'b0;
            chk("done", ls_done, 1);
            chk("wb_vld", wb_vld, t.wbv);
            if (t.wbv) begin
                chk("wb_data", wb_data, t.wbd);
                chk("wb_addr", wb_addr, t.rd);
            end
            chk("exc_vld", ls_exc_vld, t.cause != CAUSE_NONE);
            chk("exc_cause", ls_exc_cause, t.cause);
        end
        @(negedge clk);
        chk("done_pulse", ls_done, 0);
        chk("wb_pulse", wb_vld, 0);
        chk("exc_pulse", ls_exc_vld, 0);
        chk("rdy_back", ls_req_rdy, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        op      addr          wdata         rd gd rdata         err be       we bus_wdata     wbv wb_data       cause
        vecs.push_back(mk(OP_LB,  32'h0000_1003, 32'h0,         5, 2, 32'h8012_3456, 0, 4'b1000, 0, 32'h0,         1, 32'hFFFF_FF80, CAUSE_NONE));
        vecs.push_back(mk(OP_SH,  32'h0000_2002, 32'h0000_BEEF, 0, 1, 32'h0,         0, 4'b1100, 1, 32'hBEEF_BEEF, 0, 32'h0,         CAUSE_NONE));
        vecs.push_back(mk(OP_LHU, 32'h0000_0010, 32'h0,         6, 0, 32'h1234_5678, 1, 4'b0011, 0, 32'h0,         0, 32'h0,         CAUSE_BUS_ERR));
        vecs.push_back(mk(OP_LW,  32'h0000_0020, 32'h0,         0, 0, 32'h1234_5678, 0, 4'b1111, 0, 32'h0,         0, 32'h0,         CAUSE_NONE));
        vecs.push_back(mk(OP_LH,  32'h0000_0022, 32'h0,         7, 1, 32'h8001_0000, 0, 4'b1100, 0, 32'h0,         1, 32'hFFFF_8001, CAUSE_NONE));
        vecs.push_back(mk(OP_LBU, 32'h0000_0041, 32'h0,         8, 0, 32'h0000_F000, 0, 4'b0010, 0, 32'h0,         1, 32'h0000_00F0, CAUSE_NONE));
        vecs.push_back(mk(OP_SB,  32'h0000_0103, 32'h1234_56A5, 0, 2, 32'h0,         0, 4'b1000, 1, 32'hA5A5_A5A5, 0, 32'h0,         CAUSE_NONE));
        vecs.push_back(mk(OP_SW,  32'h0000_0200, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, 4'b1111, 1, 32'hDEAD_BEEF, 0, 32'h0,         CAUSE_NONE));
        vecs.push_back(mk(OP_LB,  32'h0000_0002, 32'h0,         9, 1, 32'h007F_0000, 0, 4'b0100, 0, 32'h0,         1, 32'h0000_007F, CAUSE_NONE));
        vecs.push_back(mk(OP_LHU, 32'h0000_0012, 32'h0,         31,0, 32'hABCD_0000, 0, 4'b1100, 0, 32'h0,         1, 32'h0000_ABCD, CAUSE_NONE));
        vecs.push_back(mk(OP_LW,  32'hFFFF_FFFC, 32'h0,         1, 2, 32'hCAFE_F00D, 0, 4'b1111, 0, 32'h0,         1, 32'hCAFE_F00D, CAUSE_NONE));
`ifndef PEAK_DPU_LS_MISALIGN_SPLIT_EN
        vecs.push_back(mk(OP_LW,  32'h0000_1001, 32'h0,         3, 0, 32'h0,         0, 4'b0000, 0, 32'h0,         0, 32'h0,         CAUSE_MISALIGN));
        vecs.push_back(mk(OP_LH,  32'h0000_0023, 32'h0,         3, 0, 32'h0,         0, 4'b0000, 0, 32'h0,         0, 32'h0,         CAUSE_MISALIGN));
        vecs.push_back(mk(OP_SH,  32'h0000_2001, 32'h0000_1111, 0, 0, 32'h0,         0, 4'b0000, 0, 32'h0,         0, 32'h0,         CAUSE_MISALIGN));
        vecs.push_back(mk(OP_SW,  32'h0000_2002, 32'h0000_1111, 0, 0, 32'h0,         0, 4'b0000, 0, 32'h0,         0, 32'h0,         CAUSE_MISALIGN));
`endif

        // Reset values
        #1;
        chk("rst_rdy", ls_req_rdy, 1);
        chk("rst_req", dbus_req, 0);
        chk("rst_addr", dbus_addr, 0);
        chk("rst_we", dbus_we, 0);
        chk("rst_be", dbus_be, 0);
        chk("rst_wdata", dbus_wdata, 0);
        chk("rst_wb_vld", wb_vld, 0);
        chk("rst_done", ls_done, 0);
        chk("rst_exc", ls_exc_vld, 0);
        chk("rst_cause", ls_exc_cause, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            run_vec(v);
        end

        // Grant never comes: abort after four cycles, late response dropped.
        issue(OP_LW, 32'h0000_0300, 32'h0, 5'd4);
        chk("tmo_launch_req", dbus_req, 1);
        cyc = 0;
        while (!ls_exc_vld && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_latency", cyc, 4);
        chk("tmo_cause", ls_exc_cause, CAUSE_TIMEOUT);
        chk("tmo_req_dropped", dbus_req, 0);
        chk("tmo_done", ls_done, 1);
        chk("tmo_no_wb", wb_vld, 0);
        dbus_rvld = 1'b1; dbus_rdata = 32'h1111_2222;
        repeat (2) begin
            @(negedge clk);
            chk("tmo_late_rvld_rdy", ls_req_rdy, 1);
            chk("tmo_late_rvld_wb", wb_vld, 0);
        end
        dbus_rvld = 1'b0;
        @(negedge clk);
        chk("tmo_after_done", ls_done, 0);
        chk("tmo_after_wb", wb_vld, 0);

        // Reset while waiting for a response.
        issue(OP_LW, 32'h0000_0400, 32'h0, 5'd9);
        chk("rstw_req", dbus_req, 1);
        dbus_gnt = 1'b1;
        @(negedge clk);
        dbus_gnt = 1'b0;
        chk("rstw_busy", ls_req_rdy, 0);
        rst_n = 1'b0;
        #1;
        chk("rstw_rdy_now", ls_req_rdy, 1);
        chk("rstw_req_now", dbus_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dbus_rvld = 1'b1; dbus_rdata = 32'h5555_5555;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dbus_rvld = 1'b0;
            chk("rstw_no_wb", wb_vld, 0);
            chk("rstw_no_exc", ls_exc_vld, 0);
            chk("rstw_no_done", ls_done, 0);
        end

        // Reset while requesting drops the request at once.
        issue(OP_SW, 32'h0000_0500, 32'h1234_5678, 5'd0);
        chk("rstr_req", dbus_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rstr_req_now", dbus_req, 0);
        chk("rstr_we_now", dbus_we, 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef PEAK_DPU_LS_MISALIGN_SPLIT_EN
        // Misaligned word load split across two words.
        issue(OP_LW, 32'h0000_1001, 32'h0, 5'd3);
        chk("split_addr1", dbus_addr, 32'h0000_1000);
        chk("split_be1", dbus_be, 4'b1110);
        dbus_gnt = 1'b1;
        @(negedge clk);
        dbus_gnt = 1'b0;
        dbus_rvld = 1'b1; dbus_rdata = 32'h4433_2211;
        @(negedge clk);
        dbus_rvld = 1'b0;
        chk("split_req2", dbus_req, 1);
        chk("split_addr2", dbus_addr, 32'h0000_1004);
        chk("split_be2", dbus_be, 4'b0001);
        dbus_gnt = 1'b1;
        @(negedge clk);
        dbus_gnt = 1'b0;
        dbus_rvld = 1'b1; dbus_rdata = 32'h8877_6655;
        @(negedge clk);
        dbus_rvld = 1'b0;
        chk("split_wb_vld", wb_vld, 1);
        chk("split_wb_data", wb_data, 32'h5544_3322);
        chk("split_no_exc", ls_exc_vld, 0);
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
